stage1if: RTL and testbench

//  Instruction-fetch stage, directly upstream of stage2id. Owns the fetch PC, issues requests to a
//  1-cycle-latency synchronous instruction memory, and buffers returns in a small flushable queue.

---
 rtl/stage1if_pkg.sv | 9 +
 rtl/stage1if_fetch_queue.sv | 56 +++++
 rtl/stage1if.sv | 110 +++++++++++
 tb/tb_stage1if.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/stage1if_pkg.sv
// Shared constants for the fetch stage and its neighbours.
//   ISET_*    : instruction-set encodings exchanged with decode
//   OPC_NOP   : all-zero opcode word
//   INSTR_NOP : instruction word presented as a bubble
package stage1if_pkg;
    localparam logic [3:0]  ISET_R    = 4'h1;
    localparam logic [11:0] OPC_NOP   = 12'h000;
    localparam logic [11:0] INSTR_NOP = OPC_NOP;
endpackage

// File: rtl/stage1if_fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} words.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   enq        : write enq_data at the tail
//   enq_data   : {pc, instr} being written
//   deq        : pop the head (caller only pops when count > 0)
//   flush      : drop all entries; wins over a simultaneous enq
//   count      : number of valid entries
//   head       : oldest entry, valid whenever count > 0
module stage1if_fetch_queue #(
    parameter int W     = 24,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq,
    input  logic [W-1:0]  enq_data,
    input  logic          deq,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);
    localparam int              PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // The issue credit upstream makes these unreachable.
            if (enq && !deq) assert (count != FULL);
            if (deq) assert (count != '0);
            if (enq) begin
                mem[wr_ptr] <= enq_data;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (deq) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(enq) - CW'(deq);
        end
    end
endmodule

// File: rtl/stage1if.sv
// Instruction-fetch stage. Owns the fetch PC, issues reads to a 1-cycle
// synchronous instruction memory, buffers returns and presents them to decode.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   enable_in / enable_out  : global stage enable (freeze when low), passed through
//   stall_in                : decode hazard stall, holds the presented instruction
//   branch_taken_in/_pc_in  : redirect from execute, discards wrong-path work
//   set_in / instr_set_out  : instruction set fed back from decode, registered
//   imem_req_out/_addr_out  : memory read request and address (= fetch PC)
//   imem_data_in            : read data, valid the cycle after a request
//   pc_out/instr_out/valid_out : presented instruction
module stage1if
    import stage1if_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter int                INSTR_W  = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                FQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_in,
    output logic               enable_out,
    input  logic               stall_in,
    input  logic               branch_taken_in,
    input  logic [ADDR_W-1:0]  branch_pc_in,
    input  logic [3:0]         set_in,
    output logic               imem_req_out,
    output logic [ADDR_W-1:0]  imem_addr_out,
    input  logic [INSTR_W-1:0] imem_data_in,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [3:0]         instr_set_out,
    output logic               valid_out
);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int EW = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0] fetch_pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [CW-1:0]     q_count;
    logic [EW-1:0]     q_head;
    logic [CW:0]       occ;
    logic              flush, accept, deq, bypass, enq, issue;

    assign enable_out    = enable_in;
    assign flush         = enable_in & branch_taken_in;
    // Output register can take a new instruction this cycle.
    assign accept        = enable_in & ~branch_taken_in & (~stall_in | ~valid_out);
    assign deq           = accept & (q_count != '0);
    // A return that finds the queue empty goes straight to the output register;
    // this is what gives valid_out two cycles after the request.
    assign bypass        = accept & (q_count == '0) & inflight;
    assign enq           = inflight & ~bypass & ~flush;
    // Credit: queued + in-flight words after this cycle's pop must leave room.
    assign occ           = {1'b0, q_count} + (CW+1)'(inflight) - (CW+1)'(deq);
    assign issue         = ~rst & enable_in & ~branch_taken_in & (occ < (CW+1)'(FQ_DEPTH));
    assign imem_req_out  = issue;
    assign imem_addr_out = fetch_pc;

    stage1if_fetch_queue #(.W(EW), .DEPTH(FQ_DEPTH), .CW(CW)) u_fetch_queue (
        .clk      (clk),
        .rst      (rst),
        .enq      (enq),
        .enq_data ({inflight_pc, imem_data_in}),
        .deq      (deq),
        .flush    (flush),
        .count    (q_count),
        .head     (q_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc      <= RESET_PC;
            inflight      <= 1'b0;
            inflight_pc   <= '0;
            pc_out        <= '0;
            instr_out     <= INSTR_W'(INSTR_NOP);
            instr_set_out <= ISET_R;
            valid_out     <= 1'b0;
        end else begin
            if (enable_in) begin
                instr_set_out <= set_in;
                if (branch_taken_in) begin
                    fetch_pc <= branch_pc_in;
                end else if (issue) begin
                    fetch_pc    <= fetch_pc + 1'b1;
                    inflight_pc <= fetch_pc;
                end
            end
            // Cleared on branch (wrong path) and when frozen (return already captured).
            inflight <= issue;
            if (flush) begin
                instr_out <= INSTR_W'(INSTR_NOP);
                valid_out <= 1'b0;
            end else if (deq) begin
                {pc_out, instr_out} <= q_head;
                valid_out           <= 1'b1;
            end else if (bypass) begin
                pc_out    <= inflight_pc;
                instr_out <= imem_data_in;
                valid_out <= 1'b1;
            end else if (accept) begin
                instr_out <= INSTR_W'(INSTR_NOP);
                valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stage1if.sv
module tb_stage1if;
    import stage1if_pkg::*;

    logic        clk = 1'b0;
    logic        rst, enable_in, stall_in, branch_taken_in;
    logic [11:0] branch_pc_in;
    logic [3:0]  set_in;
    logic        enable_out, imem_req_out, valid_out;
    logic [11:0] imem_addr_out, imem_data_in, pc_out, instr_out;
    logic [3:0]  instr_set_out;
    logic [11:0] xk = 12'h000;
    int          tests = 0;
    int          fails = 0;

    stage1if dut (
        .clk(clk), .rst(rst), .enable_in(enable_in), .enable_out(enable_out),
        .stall_in(stall_in), .branch_taken_in(branch_taken_in), .branch_pc_in(branch_pc_in),
        .set_in(set_in), .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
        .imem_data_in(imem_data_in), .pc_out(pc_out), .instr_out(instr_out),
        .instr_set_out(instr_set_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    // 1-cycle synchronous memory; data = addr ^ xk, junk when not requested.
    always @(posedge clk) imem_data_in <= imem_req_out ? (imem_addr_out ^ xk) : 12'hBAD;

    typedef struct {
        logic en, st, br; logic [11:0] bpc;
        logic req; logic [11:0] addr; logic vld; logic [11:0] pc;
    } vec_t;
    vec_t tbl[32];

    function automatic vec_t mk(logic en, logic st, logic br, logic [11:0] bpc,
                                logic req, logic [11:0] addr, logic vld, logic [11:0] pc);
        vec_t v;
        v.en = en; v.st = st; v.br = br; v.bpc = bpc;
        v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @c%0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_out(input int cyc, input logic req, input logic [11:0] addr,
                           input logic vld, input logic [11:0] pc, input logic [11:0] ins,
                           input logic [3:0] iset);
        chk("imem_req", cyc, 32'(imem_req_out), 32'(req));
        chk("imem_addr", cyc, 32'(imem_addr_out), 32'(addr));
        chk("valid_out", cyc, 32'(valid_out), 32'(vld));
        chk("pc_out", cyc, 32'(pc_out), 32'(pc));
        chk("instr_out", cyc, 32'(instr_out), 32'(ins));
        chk("instr_set", cyc, 32'(instr_set_out), 32'(iset));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //             en st br bpc      req addr    vld pc
        tbl[0]  = mk(1, 0, 0, 12'h000, 1, 12'h000, 0, 12'h000);
        tbl[1]  = mk(1, 0, 0, 12'h000, 1, 12'h001, 0, 12'h000);
        tbl[2]  = mk(1, 0, 0, 12'h000, 1, 12'h002, 1, 12'h000);
        tbl[3]  = mk(1, 0, 0, 12'h000, 1, 12'h003, 1, 12'h001);
        tbl[4]  = mk(1, 0, 0, 12'h000, 1, 12'h004, 1, 12'h002);
        tbl[5]  = mk(1, 0, 0, 12'h000, 1, 12'h005, 1, 12'h003);
        tbl[6]  = mk(1, 0, 0, 12'h000, 1, 12'h006, 1, 12'h004);
        // stall 3 cycles at pc 5: queue fills, requests stop
        tbl[7]  = mk(1, 1, 0, 12'h000, 1, 12'h007, 1, 12'h005);
        tbl[8]  = mk(1, 1, 0, 12'h000, 0, 12'h008, 1, 12'h005);
        tbl[9]  = mk(1, 1, 0, 12'h000, 0, 12'h008, 1, 12'h005);
        tbl[10] = mk(1, 0, 0, 12'h000, 1, 12'h008, 1, 12'h005);
        tbl[11] = mk(1, 0, 0, 12'h000, 1, 12'h009, 1, 12'h006);
        tbl[12] = mk(1, 0, 0, 12'h000, 1, 12'h00A, 1, 12'h007);
        // stall to fill the queue, then branch to 040 while stalled
        tbl[13] = mk(1, 1, 0, 12'h000, 0, 12'h00B, 1, 12'h008);
        tbl[14] = mk(1, 1, 1, 12'h040, 0, 12'h00B, 1, 12'h008);
        tbl[15] = mk(1, 0, 0, 12'h000, 1, 12'h040, 0, 12'h008);
        tbl[16] = mk(1, 0, 0, 12'h000, 1, 12'h041, 0, 12'h008);
        tbl[17] = mk(1, 0, 0, 12'h000, 1, 12'h042, 1, 12'h040);
        tbl[18] = mk(1, 0, 0, 12'h000, 1, 12'h043, 1, 12'h041);
        // branch to FFE with a return in flight: wraps to 000
        tbl[19] = mk(1, 0, 1, 12'hFFE, 0, 12'h044, 1, 12'h042);
        tbl[20] = mk(1, 0, 0, 12'h000, 1, 12'hFFE, 0, 12'h042);
        tbl[21] = mk(1, 0, 0, 12'h000, 1, 12'hFFF, 0, 12'h042);
        tbl[22] = mk(1, 0, 0, 12'h000, 1, 12'h000, 1, 12'hFFE);
        tbl[23] = mk(1, 0, 0, 12'h000, 1, 12'h001, 1, 12'hFFF);
        tbl[24] = mk(1, 0, 0, 12'h000, 1, 12'h002, 1, 12'h000);
        tbl[25] = mk(1, 0, 0, 12'h000, 1, 12'h003, 1, 12'h001);
        // enable low 2 cycles, in-flight word 003 kept
        tbl[26] = mk(0, 0, 0, 12'h000, 0, 12'h004, 1, 12'h002);
        tbl[27] = mk(0, 0, 0, 12'h000, 0, 12'h004, 1, 12'h002);
        tbl[28] = mk(1, 0, 0, 12'h000, 1, 12'h004, 1, 12'h002);
        tbl[29] = mk(1, 0, 0, 12'h000, 1, 12'h005, 1, 12'h003);
        tbl[30] = mk(1, 0, 0, 12'h000, 1, 12'h006, 1, 12'h004);
        tbl[31] = mk(1, 0, 0, 12'h000, 1, 12'h007, 1, 12'h005);

        rst = 1'b1; enable_in = 1'b1; stall_in = 1'b0; branch_taken_in = 1'b0;
        branch_pc_in = 12'h000; set_in = 4'h2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_out(-1, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, ISET_R);

        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            enable_in = tbl[k].en; stall_in = tbl[k].st;
            branch_taken_in = tbl[k].br; branch_pc_in = tbl[k].bpc;
            @(negedge clk);
            chk_out(k, tbl[k].req, tbl[k].addr, tbl[k].vld, tbl[k].pc,
                    tbl[k].vld ? tbl[k].pc : 12'h000, (k == 0) ? ISET_R : 4'h2);
            chk("enable_out", k, 32'(enable_out), 32'(tbl[k].en));
        end

        // reset mid-stream with return 007 in flight
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req", 32, 32'(imem_req_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; set_in = 4'h3; xk = 12'h5A5;
        @(negedge clk);
        chk_out(33, 1'b1, 12'h000, 1'b0, 12'h000, 12'h000, ISET_R);
        @(posedge clk); #1;
        @(negedge clk);
        chk_out(34, 1'b1, 12'h001, 1'b0, 12'h000, 12'h000, 4'h3);
        @(posedge clk); #1;
        @(negedge clk);
        chk_out(35, 1'b1, 12'h002, 1'b1, 12'h000, 12'h5A5, 4'h3);
        @(posedge clk); #1;
        @(negedge clk);
        chk_out(36, 1'b1, 12'h003, 1'b1, 12'h001, 12'h5A4, 4'h3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
